cmp_trend_monitor: RTL and testbench

CMP_TREND_MONITOR -- requirements
Module: cmp_trend_monitor

---
 rtl/cmp_trend_monitor.sv | 120 ++++++++++++
 tb/tb_cmp_trend_monitor.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cmp_trend_monitor.sv
// Debounced trend monitor for a three-flag magnitude comparator.
// Tracks per-outcome saturating counts and latches illegal flag combinations.
module cmp_trend_monitor #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             A_less_B,
  input  logic             A_greater_B,
  input  logic             A_equal_B,
  input  logic             clear,
  output logic [1:0]       state_out,
  output logic             state_change,
  output logic [CNT_W-1:0] less_cnt,
  output logic [CNT_W-1:0] greater_cnt,
  output logic [CNT_W-1:0] equal_cnt,
  output logic             flag_err
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'b00,
    ST_LESS    = 2'b01,
    ST_GREATER = 2'b10,
    ST_EQUAL   = 2'b11
  } state_t;

  localparam logic [3:0] RUN_MAX = 4'(DEBOUNCE);

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] sat_inc_run(input logic [3:0] v);
    return (v >= RUN_MAX) ? RUN_MAX : v + 4'd1;
  endfunction

  logic [2:0] flags;
  logic       onehot;
  logic       accept;
  logic       illegal;
  state_t     outcome;
  state_t     state_q;
  state_t     state_d;
  state_t     last_p0;
  logic [3:0] run_p0;
  logic [3:0] run_nxt;
  logic       chg_p0;

  assign flags   = {A_equal_B, A_greater_B, A_less_B};
  assign onehot  = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign accept  = in_valid && onehot;
  assign illegal = in_valid && !onehot;

  always_comb begin
    outcome = ST_UNKNOWN;
    if (A_less_B)         outcome = ST_LESS;
    else if (A_greater_B) outcome = ST_GREATER;
    else if (A_equal_B)   outcome = ST_EQUAL;
  end

  // "No outcome yet" is encoded as ST_UNKNOWN, so the first sample always starts a new run.
  always_comb begin
    run_nxt = 4'd1;
    if (outcome == last_p0) run_nxt = sat_inc_run(run_p0);
  end

  always_comb begin
    state_d = state_q;
    if (accept && (run_nxt == RUN_MAX) && (outcome != state_q)) state_d = outcome;
  end

  // Stage p0: state register, change pulse and run tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_UNKNOWN;
      chg_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      chg_p0  <= (state_d != state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_p0  <= 4'd0;
      last_p0 <= ST_UNKNOWN;
    end else if (accept) begin
      run_p0  <= run_nxt;
      last_p0 <= outcome;
    end
  end

  // Stage p0: statistics; clear beats counting, an illegal sample beats clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      less_cnt    <= '0;
      greater_cnt <= '0;
      equal_cnt   <= '0;
      flag_err    <= 1'b0;
    end else begin
      if (clear) begin
        less_cnt    <= '0;
        greater_cnt <= '0;
        equal_cnt   <= '0;
      end else if (accept) begin
        if (outcome == ST_LESS)    less_cnt    <= sat_inc_cnt(less_cnt);
        if (outcome == ST_GREATER) greater_cnt <= sat_inc_cnt(greater_cnt);
        if (outcome == ST_EQUAL)   equal_cnt   <= sat_inc_cnt(equal_cnt);
      end
      if (illegal)    flag_err <= 1'b1;
      else if (clear) flag_err <= 1'b0;
    end
  end

  assign state_out    = state_q;
  assign state_change = chg_p0;

endmodule

// File: tb/tb_cmp_trend_monitor.sv
// Scoreboard bench for cmp_trend_monitor: directed steps push hand-computed
// expected outputs; an independent monitor pops and compares each cycle.
module tb_cmp_trend_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       A_less_B;
  logic       A_greater_B;
  logic       A_equal_B;
  logic       clear;
  logic [1:0] state_out;
  logic       state_change;
  logic [3:0] less_cnt;
  logic [3:0] greater_cnt;
  logic [3:0] equal_cnt;
  logic       flag_err;

  typedef struct {
    int         id;
    logic [1:0] st;
    logic       chg;
    logic [3:0] lc;
    logic [3:0] gc;
    logic [3:0] ec;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  cmp_trend_monitor #(.DEBOUNCE(3), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .A_less_B(A_less_B), .A_greater_B(A_greater_B), .A_equal_B(A_equal_B),
    .clear(clear), .state_out(state_out), .state_change(state_change),
    .less_cnt(less_cnt), .greater_cnt(greater_cnt), .equal_cnt(equal_cnt),
    .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic l, input logic g, input logic e,
                      input logic clr, input logic rn,
                      input int est, input int echg, input int elc, input int egc,
                      input int eec, input int eerr);
    exp_t x;
    in_valid = v; A_less_B = l; A_greater_B = g; A_equal_B = e;
    clear = clr; rst_n = rn;
    @(posedge clk);
    step_id++;
    x.id = step_id; x.st = 2'(est); x.chg = 1'(echg);
    x.lc = 4'(elc); x.gc = 4'(egc); x.ec = 4'(eec); x.err = 1'(eerr);
    q.push_back(x);
    #2;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("state_out",    x.id, 8'(state_out),    8'(x.st));
        chk("state_change", x.id, 8'(state_change), 8'(x.chg));
        chk("less_cnt",     x.id, 8'(less_cnt),     8'(x.lc));
        chk("greater_cnt",  x.id, 8'(greater_cnt),  8'(x.gc));
        chk("equal_cnt",    x.id, 8'(equal_cnt),    8'(x.ec));
        chk("flag_err",     x.id, 8'(flag_err),     8'(x.err));
      end
    end
  end

  initial begin : stim
    int waited;
    rst_n = 1'b0; in_valid = 1'b0; A_less_B = 1'b0; A_greater_B = 1'b0;
    A_equal_B = 1'b0; clear = 1'b0;

    // reset state
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(0,0,0,0,0,0, 0,0,0,0,0,0);

    // three LESS from reset, then idle with junk flags, then confirming LESS
    step(1,1,0,0,0,1, 0,0,1,0,0,0);
    step(1,1,0,0,0,1, 0,0,2,0,0,0);
    step(1,1,0,0,0,1, 1,1,3,0,0,0);
    step(0,1,1,0,0,1, 1,0,3,0,0,0);
    step(1,1,0,0,0,1, 1,0,4,0,0,0);

    // L,L,G,G,G with idle gaps: 00 -> 10 directly
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(1,1,0,0,0,1, 0,0,1,0,0,0);
    step(0,0,0,0,0,1, 0,0,1,0,0,0);
    step(1,1,0,0,0,1, 0,0,2,0,0,0);
    step(0,0,0,0,0,1, 0,0,2,0,0,0);
    step(1,0,1,0,0,1, 0,0,2,1,0,0);
    step(0,0,0,0,0,1, 0,0,2,1,0,0);
    step(1,0,1,0,0,1, 0,0,2,2,0,0);
    step(0,0,0,0,0,1, 0,0,2,2,0,0);
    step(1,0,1,0,0,1, 2,1,2,3,0,0);
    step(0,0,0,0,0,1, 2,0,2,3,0,0);

    // twenty EQUAL: counter saturates at 15, single pulse at the 3rd
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    for (int k = 1; k <= 20; k++)
      step(1,0,0,1,0,1, (k >= 3) ? 3 : 0, (k == 3) ? 1 : 0, 0, 0, (k > 15) ? 15 : k, 0);

    // illegal combinations, then clear
    step(1,1,0,1,0,1, 3,0,0,0,15,1);
    step(1,0,0,0,0,1, 3,0,0,0,15,1);
    step(1,1,1,1,0,1, 3,0,0,0,15,1);
    step(0,0,0,0,1,1, 3,0,0,0,0,0);
    step(1,0,0,1,0,1, 3,0,0,0,1,0);

    // clear on the 3rd GREATER: count dropped, debounce still fires
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(1,0,1,0,0,1, 0,0,0,1,0,0);
    step(1,0,1,0,0,1, 0,0,0,2,0,0);
    step(1,0,1,0,1,1, 2,1,0,0,0,0);
    step(0,0,0,0,0,1, 2,0,0,0,0,0);
    step(1,0,1,0,0,1, 2,0,0,1,0,0);

    // illegal plus clear: set wins; then plain clear
    step(1,1,1,0,1,1, 2,0,0,0,0,1);
    step(0,0,0,0,1,1, 2,0,0,0,0,0);

    // reset mid-run (with valid and clear asserted) discards the run
    step(0,0,0,0,0,0, 0,0,0,0,0,0);
    step(1,0,1,0,0,1, 0,0,0,1,0,0);
    step(1,0,1,0,0,1, 0,0,0,2,0,0);
    step(1,0,1,0,1,0, 0,0,0,0,0,0);
    step(1,0,1,0,0,1, 0,0,0,1,0,0);
    step(1,0,1,0,0,1, 0,0,0,2,0,0);
    step(1,0,1,0,0,1, 2,1,0,3,0,0);

    // GREATER -> EQUAL directly
    step(1,0,0,1,0,1, 2,0,0,3,1,0);
    step(1,0,0,1,0,1, 2,0,0,3,2,0);
    step(1,0,0,1,0,1, 3,1,0,3,3,0);
    step(0,0,0,0,0,1, 3,0,0,3,3,0);

    waited = 0;
    while (q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
